// File: rtl/router_pkg.sv
// Shared widths, header field positions and the stored entry layout for the router output FIFOs.
package router_pkg;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_LSB   = 0;
    localparam int LEN_LSB    = 2;

    typedef struct packed {
        logic              lfd;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/router_fifo_ptr.sv
// One FIFO pointer with natural wrap mod 2*DEPTH; compares against the opposite pointer
// to report "same position" (empty) and "one lap apart" (full).
module router_fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W:0]   other_ptr,
    output logic [ADDR_W:0]   ptr,
    output logic              same,
    output logic              lapped
);
    logic [ADDR_W:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr    = ptr_q;
    assign same   = (ptr_q == other_ptr);
    assign lapped = (ptr_q[ADDR_W] != other_ptr[ADDR_W]) &&
                    (ptr_q[ADDR_W-1:0] == other_ptr[ADDR_W-1:0]);
endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router with header-driven packet counter and soft flush.
// Optional sticky overflow/underflow flag enabled by defining ROUTER_FIFO_ERR_EN.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = WIDTH - 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_W:0]  wp, rp;
    logic             wp_same, wp_lapped, rp_same, rp_lapped;
    logic             wr_ok, rd_ok;
    logic [WIDTH:0]   rd_entry;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] dout_d, dout_q;

    assign empty = wp_same & rp_same;
    assign full  = wp_lapped & rp_lapped;

    assign wr_ok    = write_enb && !full && !soft_reset;
    assign rd_ok    = read_enb && !empty && !soft_reset;
    assign rd_entry = mem_q[rp[ADDR_W-1:0]];

    router_fifo_ptr #(.ADDR_W(ADDR_W)) u_wp (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (soft_reset),
        .inc       (wr_ok),
        .other_ptr (rp),
        .ptr       (wp),
        .same      (wp_same),
        .lapped    (wp_lapped)
    );

    router_fifo_ptr #(.ADDR_W(ADDR_W)) u_rp (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (soft_reset),
        .inc       (rd_ok),
        .other_ptr (wp),
        .ptr       (rp),
        .same      (rp_same),
        .lapped    (rp_lapped)
    );

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (resetn && wr_ok) begin
            mem_q[wp[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    // A header loads payload length plus the trailing parity byte; the bus idles at 0 between packets.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (soft_reset) begin
            cnt_d  = '0;
            dout_d = '0;
        end else if (rd_ok) begin
            dout_d = rd_entry[WIDTH-1:0];
            if (rd_entry[WIDTH]) begin
                cnt_d = CNT_W'(rd_entry[WIDTH-1:LEN_LSB]) + CNT_W'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (cnt_q == '0) begin
            dout_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

`ifdef ROUTER_FIFO_ERR_EN
    logic err_d, err_q;

    always_comb begin
        err_d = err_q | (write_enb & full) | (read_enb & empty);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_router_fifo.sv
// Randomized and directed bench for router_fifo against a queue-based packet model.
// Defining ROUTER_FIFO_ERR_EN enables the sticky err expectations.
module tb_router_fifo;
    import router_pkg::*;

`ifdef ROUTER_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clock;
    logic              resetn;
    logic              soft_reset;
    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              err;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: FIFO contents, packet counter, expected output bus and error flag.
    fifo_entry_t       exp_q[$];
    int                exp_cnt;
    logic [DATA_W-1:0] exp_dout;
    logic              exp_err;
    int                n_checks;
    int                n_errors;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, ".full"}, 32'(full), 32'(exp_q.size() == FIFO_DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic do_reset(input string tag);
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = '0;
        exp_q.delete();
        exp_cnt  = 0;
        exp_dout = '0;
        exp_err  = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        check_outputs(tag);
    endtask

    // One clock of traffic: model updates from start-of-cycle occupancy, then outputs are compared.
    task automatic step(input string tag, input logic we, input logic lfd, input logic [DATA_W-1:0] din,
                        input logic re, input logic sr);
        bit          full_m;
        bit          empty_m;
        fifo_entry_t e;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        full_m  = (exp_q.size() == FIFO_DEPTH);
        empty_m = (exp_q.size() == 0);
        if (ERR_EN && ((we && full_m) || (re && empty_m))) exp_err = 1'b1;
        if (sr) begin
            exp_q.delete();
            exp_cnt  = 0;
            exp_dout = '0;
        end else begin
            if (re && !empty_m) begin
                e = exp_q.pop_front();
                exp_dout = e.data;
                if (e.lfd) exp_cnt = int'(e.data >> LEN_LSB) + 1;
                else if (exp_cnt != 0) exp_cnt--;
            end else if (exp_cnt == 0) begin
                exp_dout = '0;
            end
            if (we && !full_m) exp_q.push_back('{lfd: lfd, data: din});
        end
        @(posedge clock);
        #1;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] b;
        n_checks = 0;
        n_errors = 0;
        do_reset("init");

        // Random traffic, then a single-cycle reset mid-stream.
        for (int i = 0; i < 40; i++) begin
            step("rand_pre", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        do_reset("reset_after_traffic");

        // Header len=3 plus 4 bytes, read back as one packet followed by idle cycles.
        step("pkt_wr_hdr", 1'b1, 1'b1, 8'h0E, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("pkt_wr", 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("pkt_rd", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        step("pkt_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step("pkt_idle2", 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fill to full, overflow attempt, then drain.
        for (int i = 0; i < FIFO_DEPTH; i++) step("fill", 1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
        step("overflow", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        step("underflow", 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < FIFO_DEPTH; i++) step("fill2", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) step("drain2", 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Soft reset mid-packet with a concurrent write.
        step("sr_hdr", 1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
        step("sr_b0", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step("sr_rd", 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
        step("soft_reset", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        step("sr_after", 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Partial fills of 10 to wrap the pointers repeatedly.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) begin
                b = DATA_W'($urandom);
                step("wrap_wr", 1'b1, (i == 0), b, 1'b0, 1'b0);
            end
            for (int i = 0; i < 10; i++) step("wrap_rd", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        end

        // Mixed random traffic with occasional headers and soft resets.
        for (int i = 0; i < 400; i++) begin
            step("rand_mix", ($urandom_range(0, 99) < 60), ($urandom_range(0, 9) == 0),
                 DATA_W'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) == 0));
        end
        do_reset("final_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
